imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch controller that owns the address port of the 1024-word, combinational-read instruction memory.
- Sequences the PC and loads the IF/ID register.
- Applies hazard stalls and branch/jump redirects.
- Arbitrates the single memory port between the fetch path and a debug/trace read requester.
- Sits between the PC/hazard logic and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
IMEM_WORDS, 1024, instruction memory depth in words.
DBG_WAIT_MAX, 4, consecutive denied debug-request cycles before debug is forced a slot.

Ports:
Clk  in  1  system clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Mem_Address  out  32  byte address to instruction memory; bits [1:0] always 0.
Mem_Instruction  in  32  instruction word read combinationally from Mem_Address in the same cycle.
Stall  in  1  hazard unit: hold PC and IF/ID.
Redirect  in  1  taken branch/jump from EX.
Redirect_PC  in  32  target for Redirect.
IFID_Instruction  out  32  registered fetched instruction.
IFID_PC4  out  32  registered PC+4 of that instruction.
IFID_Valid  out  1  IF/ID holds a real instruction; 0 = bubble.
PC  out  32  current fetch PC.
Dbg_Req  in  1  debug read request; level, held until granted.
Dbg_Addr  in  32  debug byte address.
Dbg_Gnt  out  1  combinational; debug owns the port this cycle.
Dbg_Data  out  32  registered debug read data.
Dbg_Valid  out  1  one-cycle pulse, Dbg_Data valid.
Fetch_Fault  out  1  sticky out-of-range fetch flag (see Optional Feature).

Behaviour:
Reset (Reset_n=0, asynchronous):
- PC=RESET_PC; all other outputs 0.
- Starve counter = 0; state = BOOT.
- Reset mid-operation aborts everything immediately.

States:
- BOOT: one cycle only. Mem_Address=RESET_PC, no grant, IF/ID unchanged. Next state is always RUN.
- RUN: steady state.

Port owner (RUN, combinational):
- debug if Dbg_Req && (Stall || starve_cnt==DBG_WAIT_MAX); otherwise fetch.
- Dbg_Gnt = (owner==debug).
- Mem_Address = owner==debug ? {Dbg_Addr[31:2],2'b00} : PC.

Clock edge, priority order:
1. Redirect=1:
   - PC<={Redirect_PC[31:2],2'b00}.
   - IFID_Valid<=0, IFID_Instruction<=0, IFID_PC4<=0 (flush).
   - Overrides Stall and any fetch. A debug grant in the same cycle is still served.
2. Else owner==debug and Stall=0 (forced slot):
   - PC held; IFID_Valid<=0 (bubble inserted).
3. Else Stall=1:
   - PC and all IFID_* held.
4. Else normal fetch:
   - IFID_Instruction<=Mem_Instruction, IFID_PC4<=PC+4, IFID_Valid<=1.
   - PC<=PC+4, wrapping modulo 2^32.

Debug read:
- Dbg_Gnt=1 at an edge -> next cycle Dbg_Data<=Mem_Instruction and Dbg_Valid=1 for exactly one cycle.
- Requester drops Dbg_Req after the grant cycle.

Starve counter:
- Increments (saturating at DBG_WAIT_MAX) each RUN cycle with Dbg_Req=1 and no grant.
- Clears on grant or when Dbg_Req=0.

Misc:
- Latency: instruction at PC appears in IFID one edge after PC is presented.
- Stall and redirect do not alter debug data already captured.

Optional Feature:
Macro: IMEM_BOUNDS_CHECK_EN
With the macro:
- Fetch with PC >= IMEM_WORDS*4 loads IFID_Instruction<=0, IFID_Valid<=0, and sets Fetch_Fault=1, sticky until reset.
- PC still advances.
- An out-of-range debug read returns Dbg_Data=0 and does not set the fault.
Without the macro:
- Fetch_Fault is tied 0.
- Addresses pass through unchanged; the memory aliases modulo depth.

Test Plan:
- Release reset with RESET_PC=0 and memory[i]=i*3 -> BOOT bubble, then IFID_Instruction = 0, 3, 6 on consecutive cycles; IFID_PC4 = 4, 8, 12; IFID_Valid=1.
- Stall=1 for 3 cycles at PC=0x10 -> PC and IFID frozen; on release, fetch resumes at 0x10 (instruction 12).
- Redirect=1 with Redirect_PC=0x43 and Stall=1 in the same cycle -> PC=0x40, IFID_Valid=0, next fetch returns memory[16]=48.
- Dbg_Req with Dbg_Addr=0x20 while Stall=1 -> Dbg_Gnt same cycle; next cycle Dbg_Data=24, Dbg_Valid single pulse; PC unaffected.
- Dbg_Req held with Stall=0 -> grant on the 5th cycle (DBG_WAIT_MAX=4); exactly one IFID bubble; PC sequence continues without a skip.
- With IMEM_BOUNDS_CHECK_EN: Redirect_PC=0x1000 -> IFID_Valid=0 and Fetch_Fault=1 held; Reset_n pulse clears it.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Purpose : instruction-fetch controller; owns the instruction memory address port,
//           sequences the PC, loads IF/ID and shares the port with a debug reader.
// Latency : fetch data lands in IF/ID one edge after the PC is driven; debug data one edge after grant.
// Backpr. : stall freezes PC and IF/ID; a debug request waits for a stall or a forced slot.
//
// Ports:
//   clk, reset_n                          - clock (rising edge), async active-low reset
//   mem_address / mem_instruction         - combinational-read instruction memory port
//   stall, redirect, redirect_pc          - hazard hold and taken branch/jump target
//   ifid_instruction, ifid_pc4, ifid_valid - IF/ID pipeline register
//   pc                                    - current fetch PC
//   dbg_req, dbg_addr, dbg_gnt            - debug read request / same-cycle grant
//   dbg_data, dbg_valid                   - registered debug read data, one-cycle valid
//   fetch_fault                           - sticky out-of-range fetch flag
// Optional feature macro: IMEM_BOUNDS_CHECK_EN (fetch/debug range checking, fetch_fault).
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_WORDS   = 1024,
    parameter int          DBG_WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] pc,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic [31:0] dbg_data,
    output logic        dbg_valid,
    output logic        fetch_fault
);

`ifdef IMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam int          CW          = (DBG_WAIT_MAX < 1) ? 1 : $clog2(DBG_WAIT_MAX + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(DBG_WAIT_MAX);
    localparam logic [32:0] IMEM_BYTES  = 33'(IMEM_WORDS) << 2;
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc_q, pc_nxt;
    logic [31:0]   ifid_instr_q, ifid_instr_nxt;
    logic [31:0]   ifid_pc4_q, ifid_pc4_nxt;
    logic          ifid_vld_q, ifid_vld_nxt;
    logic [31:0]   dbg_dat_q, dbg_dat_nxt;
    logic          dbg_vld_q, dbg_vld_nxt;
    logic          fault_q, fault_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic [31:0]   dbg_addr_al;
    logic          fetch_oob;
    logic          dbg_oob;

    // Byte-offset bits of the incoming addresses are discarded by design.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{dbg_addr[1:0], redirect_pc[1:0]};

    assign dbg_addr_al = {dbg_addr[31:2], 2'b00};
    // Range checks collapse to 0 when the feature is compiled out, so the
    // memory simply aliases modulo its depth.
    assign fetch_oob   = BOUNDS_EN && ({1'b0, pc_q} >= IMEM_BYTES);
    assign dbg_oob     = BOUNDS_EN && ({1'b0, dbg_addr_al} >= IMEM_BYTES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= BOOT;
            pc_q         <= RESET_PC_AL;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_vld_q   <= 1'b0;
            dbg_dat_q    <= '0;
            dbg_vld_q    <= 1'b0;
            fault_q      <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            state        <= state_nxt;
            pc_q         <= pc_nxt;
            ifid_instr_q <= ifid_instr_nxt;
            ifid_pc4_q   <= ifid_pc4_nxt;
            ifid_vld_q   <= ifid_vld_nxt;
            dbg_dat_q    <= dbg_dat_nxt;
            dbg_vld_q    <= dbg_vld_nxt;
            fault_q      <= fault_nxt;
            starve_cnt   <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_q;
        ifid_instr_nxt = ifid_instr_q;
        ifid_pc4_nxt   = ifid_pc4_q;
        ifid_vld_nxt   = ifid_vld_q;
        dbg_dat_nxt    = dbg_dat_q;
        dbg_vld_nxt    = 1'b0;
        fault_nxt      = fault_q;
        starve_nxt     = starve_cnt;
        dbg_gnt        = 1'b0;
        mem_address    = RESET_PC_AL;

        if (state == BOOT) begin
            // Single settling cycle: memory sees the reset PC, nothing is captured.
            state_nxt = RUN;
        end else begin
            // Debug gets the port for free while fetch is stalled, or is forced
            // in once it has been denied DBG_WAIT_MAX cycles in a row.
            dbg_gnt     = dbg_req && (stall || (starve_cnt == STARVE_MAX));
            mem_address = dbg_gnt ? dbg_addr_al : pc_q;

            if (dbg_gnt) begin
                dbg_vld_nxt = 1'b1;
                dbg_dat_nxt = dbg_oob ? 32'h0 : mem_instruction;
            end

            if (!dbg_req || dbg_gnt) begin
                starve_nxt = '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_nxt = starve_cnt + 1'b1;
            end

            if (redirect) begin
                // Flush wins over stall and fetch; a same-cycle debug read still completes.
                pc_nxt         = {redirect_pc[31:2], 2'b00};
                ifid_instr_nxt = '0;
                ifid_pc4_nxt   = '0;
                ifid_vld_nxt   = 1'b0;
            end else if (dbg_gnt && !stall) begin
                // Forced debug slot stole the fetch: hold PC, present a bubble.
                ifid_vld_nxt = 1'b0;
            end else if (stall) begin
                // Hold everything.
            end else begin
                ifid_pc4_nxt = pc_q + 32'd4;
                pc_nxt       = pc_q + 32'd4;
                if (fetch_oob) begin
                    ifid_instr_nxt = '0;
                    ifid_vld_nxt   = 1'b0;
                    fault_nxt      = 1'b1;
                end else begin
                    ifid_instr_nxt = mem_instruction;
                    ifid_vld_nxt   = 1'b1;
                end
            end
        end
    end

    assign pc               = pc_q;
    assign ifid_instruction = ifid_instr_q;
    assign ifid_pc4         = ifid_pc4_q;
    assign ifid_valid       = ifid_vld_q;
    assign dbg_data         = dbg_dat_q;
    assign dbg_valid        = dbg_vld_q;
    assign fetch_fault      = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Purpose : self-checking bench for imem_fetch_ctrl with a behavioural model.
// Latency : model follows one-edge fetch and debug latency.
// Backpr. : stimulus exercises stall, redirect and debug arbitration.
module tb_imem_fetch_ctrl;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          IMEM_WORDS   = 1024;
    localparam int          DBG_WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_address, mem_instruction;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instruction, ifid_pc4, pc;
    logic        ifid_valid;
    logic        dbg_req, dbg_gnt, dbg_valid, fetch_fault;
    logic [31:0] dbg_addr, dbg_data;

    logic [31:0] mem [0:IMEM_WORDS-1];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .RESET_PC    (RESET_PC),
        .IMEM_WORDS  (IMEM_WORDS),
        .DBG_WAIT_MAX(DBG_WAIT_MAX)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .ifid_instruction(ifid_instruction),
        .ifid_pc4        (ifid_pc4),
        .ifid_valid      (ifid_valid),
        .pc              (pc),
        .dbg_req         (dbg_req),
        .dbg_addr        (dbg_addr),
        .dbg_gnt         (dbg_gnt),
        .dbg_data        (dbg_data),
        .dbg_valid       (dbg_valid),
        .fetch_fault     (fetch_fault)
    );

    // Memory contents: word i holds i*3; read is combinational and aliases.
    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'(i * 3);
    end
    assign mem_instruction = mem[mem_address[11:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_boot  = 1'b1;
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc4   = '0;
    bit          m_valid = 1'b0;
    bit          m_dv    = 1'b0;
    logic [31:0] m_dd    = '0;
    bit          m_fault = 1'b0;
    int          m_wait  = 0;   // consecutive RUN cycles debug asked and was refused

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] idx;
`ifdef IMEM_BOUNDS_CHECK_EN
        if (a >= 32'(IMEM_WORDS * 4)) return 32'h0;
`endif
        idx = (a >> 2) % 32'(IMEM_WORDS);
        return idx * 32'd3;
    endfunction

    function automatic bit m_gnt();
        return !m_boot && dbg_req && (stall || m_wait >= DBG_WAIT_MAX);
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        bit g;
        if (!reset_n) begin
            m_boot = 1'b1; m_pc = RESET_PC; m_instr = '0; m_pc4 = '0;
            m_valid = 1'b0; m_dv = 1'b0; m_dd = '0; m_fault = 1'b0; m_wait = 0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_dv   = 1'b0;
        end else begin
            g    = m_gnt();
            m_dv = g;
            if (g) m_dd = word_at({dbg_addr[31:2], 2'b00});
            if (dbg_req && !g) m_wait = (m_wait < DBG_WAIT_MAX) ? m_wait + 1 : DBG_WAIT_MAX;
            else               m_wait = 0;
            if (redirect) begin
                m_pc = {redirect_pc[31:2], 2'b00};
                m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
            end else if (g && !stall) begin
                m_valid = 1'b0;
            end else if (!stall) begin
`ifdef IMEM_BOUNDS_CHECK_EN
                if (m_pc >= 32'(IMEM_WORDS * 4)) begin
                    m_valid = 1'b0;
                    m_fault = 1'b1;
                end else m_valid = 1'b1;
`else
                m_valid = 1'b1;
`endif
                m_instr = word_at(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] exp_addr;
        exp_addr = m_boot ? RESET_PC : (m_gnt() ? {dbg_addr[31:2], 2'b00} : m_pc);
        chk("pc",          pc,                    m_pc);
        chk("ifid_instr",  ifid_instruction,      m_instr);
        chk("ifid_pc4",    ifid_pc4,              m_pc4);
        chk("ifid_valid",  32'(ifid_valid),       32'(m_valid));
        chk("dbg_valid",   32'(dbg_valid),        32'(m_dv));
        chk("dbg_data",    dbg_data,              m_dd);
        chk("fetch_fault", 32'(fetch_fault),      32'(m_fault));
        chk("dbg_gnt",     32'(dbg_gnt),          32'(m_gnt()));
        chk("mem_address", mem_address,           exp_addr);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        dbg_req = 1'b0; dbg_addr = '0;
        #2;
        chk("rst_pc",    pc,                 32'h0);
        chk("rst_valid", 32'(ifid_valid),    32'h0);
        chk("rst_dv",    32'(dbg_valid),     32'h0);
        chk("rst_fault", 32'(fetch_fault),   32'h0);
        chk("rst_gnt",   32'(dbg_gnt),       32'h0);
        tick(2);
        reset_n = 1'b1;

        tick(1);
        chk("boot_bubble", 32'(ifid_valid), 32'h0);
        chk("boot_pc",     pc,              32'h0);
        tick(1);
        chk("f0_instr", ifid_instruction, 32'd0);
        chk("f0_pc4",   ifid_pc4,         32'd4);
        chk("f0_valid", 32'(ifid_valid),  32'h1);
        tick(1);
        chk("f1_instr", ifid_instruction, 32'd3);
        chk("f1_pc4",   ifid_pc4,         32'd8);
        tick(1);
        chk("f2_instr", ifid_instruction, 32'd6);
        chk("f2_pc4",   ifid_pc4,         32'd12);
        tick(1);
        chk("pre_stall_pc", pc, 32'h10);

        stall = 1'b1;
        tick(3);
        chk("stall_pc",    pc,               32'h10);
        chk("stall_instr", ifid_instruction, 32'd9);
        stall = 1'b0;
        tick(1);
        chk("resume_instr", ifid_instruction, 32'd12);
        chk("resume_pc4",   ifid_pc4,         32'h14);

        redirect = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
        tick(1);
        redirect = 1'b0; stall = 1'b0;
        chk("redir_pc",    pc,              32'h40);
        chk("redir_valid", 32'(ifid_valid), 32'h0);
        tick(1);
        chk("redir_fetch", ifid_instruction, 32'd48);
        chk("redir_pc4",   ifid_pc4,         32'h44);

        stall = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h20;
        #1;
        chk("dbg_gnt_stall", 32'(dbg_gnt), 32'h1);
        chk("dbg_mem_addr",  mem_address,  32'h20);
        tick(1);
        dbg_req = 1'b0; stall = 1'b0;
        chk("dbg_data",  dbg_data,        32'd24);
        chk("dbg_pulse", 32'(dbg_valid),  32'h1);
        chk("dbg_pc",    pc,              32'h44);
        tick(1);
        chk("dbg_pulse_end", 32'(dbg_valid), 32'h0);
        chk("dbg_data_held", dbg_data,       32'd24);

        dbg_req = 1'b1; dbg_addr = 32'h24;
        #1;
        chk("starve_deny", 32'(dbg_gnt), 32'h0);
        tick(4);
        chk("starve_grant", 32'(dbg_gnt), 32'h1);
        chk("starve_pc",    pc,           32'h58);
        tick(1);
        dbg_req = 1'b0;
        chk("forced_bubble", 32'(ifid_valid), 32'h0);
        chk("forced_pc",     pc,              32'h58);
        chk("forced_data",   dbg_data,        32'd27);
        tick(1);
        chk("noskip_instr", ifid_instruction, 32'd66);
        chk("noskip_pc4",   ifid_pc4,         32'h5c);

        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_pc",    pc,              32'h0);
        chk("midrst_valid", 32'(ifid_valid), 32'h0);
        chk("midrst_dbg",   dbg_data,        32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(2);
        chk("reboot_instr", ifid_instruction, 32'd0);
        chk("reboot_pc",    pc,               32'h4);

`ifdef IMEM_BOUNDS_CHECK_EN
        redirect = 1'b1; redirect_pc = 32'h1000;
        tick(1);
        redirect = 1'b0;
        tick(1);
        chk("oob_valid", 32'(ifid_valid),  32'h0);
        chk("oob_instr", ifid_instruction, 32'h0);
        chk("oob_fault", 32'(fetch_fault), 32'h1);
        tick(2);
        chk("oob_sticky", 32'(fetch_fault), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("oob_cleared", 32'(fetch_fault), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(2);
`else
        redirect = 1'b1; redirect_pc = 32'h1008;
        tick(1);
        redirect = 1'b0;
        tick(1);
        chk("alias_instr", ifid_instruction, 32'd6);
        chk("alias_valid", 32'(ifid_valid),  32'h1);
        chk("alias_fault", 32'(fetch_fault), 32'h0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        tick(1);
        chk("wrap_pc",    pc,               32'h0);
        chk("wrap_pc4",   ifid_pc4,         32'h0);
        chk("wrap_instr", ifid_instruction, 32'd3069);
`endif
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
